flood_engine: RTL and testbench



---
 rtl/flood_engine.sv | 199 +++++++++++++++++++
 tb/tb_flood_engine.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flood_engine.sv
// flood_engine: Flood It playfield engine with cell storage, raster-sweep flood fill and a display read port.
// Build option: define FLOOD_DIAG_EN for 8-neighbour connectivity (default is 4-neighbour).
module flood_engine #(
    parameter int MAX_N   = 26,
    parameter int IDX_W   = 5,
    parameter int COLOR_W = 3,
    parameter int CNT_W   = 8
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic [IDX_W-1:0]   SIZE,
    input  logic [COLOR_W:0]   COLOR_NUM,
    input  logic [CNT_W-1:0]   MAX_MOVES,
    input  logic               LOAD_VALID,
    input  logic [IDX_W-1:0]   LOAD_ROW,
    input  logic [IDX_W-1:0]   LOAD_COL,
    input  logic [COLOR_W-1:0] LOAD_COLOR,
    input  logic               START,
    input  logic               MOVE_VALID,
    input  logic [COLOR_W-1:0] MOVE_COLOR,
    output logic               MOVE_READY,
    output logic               BUSY,
    output logic               WIN,
    output logic               LOSE,
    output logic [CNT_W-1:0]   MOVES,
    output logic [COLOR_W-1:0] FLOOD_COLOR,
    input  logic [IDX_W-1:0]   RD_ROW,
    input  logic [IDX_W-1:0]   RD_COL,
    output logic [COLOR_W-1:0] RD_COLOR
);
    localparam logic [IDX_W:0] MAX_N_W = (IDX_W+1)'(MAX_N);
    localparam logic [IDX_W:0] ONE_W   = (IDX_W+1)'(1);

    typedef enum logic [2:0] {ST_IDLE, ST_SWEEP, ST_CHECK, ST_PLAY, ST_WIN, ST_LOSE} state_t;
    state_t state, state_next;

    logic [COLOR_W-1:0] colors [MAX_N][MAX_N];
    logic               flags  [MAX_N][MAX_N];
    logic [IDX_W:0]     size_q;
    logic [COLOR_W:0]   color_num_q;
    logic [CNT_W-1:0]   max_moves_q;
    logic [CNT_W-1:0]   moves_q;
    logic [COLOR_W-1:0] flood_q;
    logic [IDX_W-1:0]   row;
    logic [IDX_W-1:0]   col;
    logic               changed;
    logic               all_flagged;

    logic [IDX_W:0] last_idx;
    logic [IDX_W:0] size_clamped;
    logic has_up, has_dn, has_lf, has_rt;
    logic nb_flagged, cell_set, cell_now, last_cell, changed_any;
    logic move_fire, move_eff, load_ok;

    always_comb begin
        last_idx = size_q - ONE_W;
        has_up   = (row != '0);
        has_dn   = ({1'b0, row} < last_idx);
        has_lf   = (col != '0);
        has_rt   = ({1'b0, col} < last_idx);
        nb_flagged = (has_up && flags[row - 1'b1][col]) ||
                     (has_dn && flags[row + 1'b1][col]) ||
                     (has_lf && flags[row][col - 1'b1]) ||
                     (has_rt && flags[row][col + 1'b1]);
`ifdef FLOOD_DIAG_EN
        nb_flagged = nb_flagged ||
                     (has_up && has_lf && flags[row - 1'b1][col - 1'b1]) ||
                     (has_up && has_rt && flags[row - 1'b1][col + 1'b1]) ||
                     (has_dn && has_lf && flags[row + 1'b1][col - 1'b1]) ||
                     (has_dn && has_rt && flags[row + 1'b1][col + 1'b1]);
`endif
        cell_set    = (state == ST_SWEEP) && !flags[row][col] &&
                      (colors[row][col] == flood_q) && nb_flagged;
        cell_now    = flags[row][col] | cell_set;
        last_cell   = ({1'b0, row} == last_idx) && ({1'b0, col} == last_idx);
        changed_any = changed | cell_set;
        move_fire   = (state == ST_PLAY) && MOVE_VALID && !START;
        move_eff    = move_fire && (MOVE_COLOR != flood_q) && ({1'b0, MOVE_COLOR} < color_num_q);
        load_ok     = LOAD_VALID && ({1'b0, LOAD_ROW} < MAX_N_W) && ({1'b0, LOAD_COL} < MAX_N_W);
        if (SIZE == '0)
            size_clamped = ONE_W;
        else if ({1'b0, SIZE} > MAX_N_W)
            size_clamped = MAX_N_W;
        else
            size_clamped = {1'b0, SIZE};
    end

    always_comb begin
        state_next = state;
        if (START) begin
            state_next = ST_SWEEP;
        end else begin
            case (state)
                ST_SWEEP: if (last_cell && !changed_any) state_next = ST_CHECK;
                ST_CHECK: begin
                    if (all_flagged)
                        state_next = ST_WIN;
                    else if (max_moves_q != '0 && moves_q >= max_moves_q)
                        state_next = ST_LOSE;
                    else
                        state_next = ST_PLAY;
                end
                ST_PLAY:  if (move_eff) state_next = ST_SWEEP;
                default:  state_next = state;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // all_flagged accumulates over one pass and is re-armed whenever a new pass begins
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            for (int r = 0; r < MAX_N; r++) begin
                for (int c = 0; c < MAX_N; c++) begin
                    colors[r][c] <= '0;
                    flags[r][c]  <= 1'b0;
                end
            end
            size_q      <= '0;
            color_num_q <= '0;
            max_moves_q <= '0;
            moves_q     <= '0;
            flood_q     <= '0;
            row         <= '0;
            col         <= '0;
            changed     <= 1'b0;
            all_flagged <= 1'b0;
        end else if (START) begin
            for (int r = 0; r < MAX_N; r++) begin
                for (int c = 0; c < MAX_N; c++) begin
                    flags[r][c] <= 1'b0;
                end
            end
            flags[0][0] <= 1'b1;
            size_q      <= size_clamped;
            color_num_q <= COLOR_NUM;
            max_moves_q <= MAX_MOVES;
            moves_q     <= '0;
            flood_q     <= colors[0][0];
            row         <= '0;
            col         <= '0;
            changed     <= 1'b0;
            all_flagged <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: if (load_ok) colors[LOAD_ROW][LOAD_COL] <= LOAD_COLOR;
                ST_SWEEP: begin
                    if (cell_set) flags[row][col] <= 1'b1;
                    if (last_cell) begin
                        row         <= '0;
                        col         <= '0;
                        changed     <= 1'b0;
                        all_flagged <= changed_any ? 1'b1 : (all_flagged & cell_now);
                    end else begin
                        changed     <= changed_any;
                        all_flagged <= all_flagged & cell_now;
                        if ({1'b0, col} == last_idx) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (move_eff) begin
                        if (moves_q != '1) moves_q <= moves_q + 1'b1;
                        flood_q     <= MOVE_COLOR;
                        row         <= '0;
                        col         <= '0;
                        changed     <= 1'b0;
                        all_flagged <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        RD_COLOR = '0;
        if ({1'b0, RD_ROW} < size_q && {1'b0, RD_COL} < size_q)
            RD_COLOR = flags[RD_ROW][RD_COL] ? flood_q : colors[RD_ROW][RD_COL];
    end

    assign MOVE_READY  = (state == ST_PLAY) && !START;
    assign BUSY        = (state == ST_SWEEP) || (state == ST_CHECK);
    assign WIN         = (state == ST_WIN);
    assign LOSE        = (state == ST_LOSE);
    assign MOVES       = moves_q;
    assign FLOOD_COLOR = flood_q;

endmodule

// File: tb/tb_flood_engine.sv
// tb_flood_engine: randomized scoreboard bench for flood_engine against a flood-fill reference model.
// Define FLOOD_DIAG_EN here as well as in the RTL to check 8-neighbour connectivity.
`timescale 1ns/1ps
module tb_flood_engine;
    localparam int MAX_N   = 6;
    localparam int IDX_W   = 3;
    localparam int COLOR_W = 3;
    localparam int CNT_W   = 8;
    localparam int DISP_W  = MAX_N * MAX_N * COLOR_W;
    localparam int K_RST = 0, K_DONE = 1, K_IGN = 2;
    localparam int P_PLAY = 0, P_WIN = 1, P_LOSE = 2, P_IDLE = 3;

    logic               clock = 1'b0;
    logic               reset_n;
    logic [IDX_W-1:0]   size;
    logic [COLOR_W:0]   color_num;
    logic [CNT_W-1:0]   max_moves;
    logic               load_valid;
    logic [IDX_W-1:0]   load_row, load_col;
    logic [COLOR_W-1:0] load_color;
    logic               start;
    logic               move_valid;
    logic [COLOR_W-1:0] move_color;
    logic               move_ready, busy, win, lose;
    logic [CNT_W-1:0]   moves;
    logic [COLOR_W-1:0] flood_color;
    logic [IDX_W-1:0]   rd_row, rd_col;
    logic [COLOR_W-1:0] rd_color;

    flood_engine #(.MAX_N(MAX_N), .IDX_W(IDX_W), .COLOR_W(COLOR_W), .CNT_W(CNT_W)) dut (
        .CLOCK(clock), .RESET_N(reset_n), .SIZE(size), .COLOR_NUM(color_num),
        .MAX_MOVES(max_moves), .LOAD_VALID(load_valid), .LOAD_ROW(load_row),
        .LOAD_COL(load_col), .LOAD_COLOR(load_color), .START(start),
        .MOVE_VALID(move_valid), .MOVE_COLOR(move_color), .MOVE_READY(move_ready),
        .BUSY(busy), .WIN(win), .LOSE(lose), .MOVES(moves), .FLOOD_COLOR(flood_color),
        .RD_ROW(rd_row), .RD_COL(rd_col), .RD_COLOR(rd_color)
    );

    always #5 clock = ~clock;

    typedef struct {
        int kind;
        int moves;
        int flood;
        int win;
        int lose;
        int ready;
        int lat;
        logic [DISP_W-1:0] disp;
    } exp_t;

    exp_t sb[$];
    int total = 0, bad = 0;
    int cycle = 0, op_cycle = 0;
    bit hs_seen = 0, rst_seen = 0, busy_prev = 0;

    int m_color [MAX_N][MAX_N];
    bit m_flag  [MAX_N][MAX_N];
    int m_size, m_num, m_max, m_moves, m_flood, m_phase, m_passes;

    task automatic check_output(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_disp(input logic [DISP_W-1:0] act, input logic [DISP_W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL board actual=%h required=%h", act, req);
        end
    endtask

    function automatic bit m_flag_at(input int r, input int c);
        if (r < 0 || c < 0 || r >= m_size || c >= m_size) return 1'b0;
        return m_flag[r][c];
    endfunction

    // Repeated raster passes until one adds nothing, then classify the result
    function automatic void m_flood_run();
        bit any, touch, all;
        m_passes = 0;
        do begin
            any = 0;
            m_passes++;
            for (int r = 0; r < m_size; r++) begin
                for (int c = 0; c < m_size; c++) begin
                    if (!m_flag[r][c] && m_color[r][c] == m_flood) begin
                        touch = m_flag_at(r-1, c) | m_flag_at(r+1, c) | m_flag_at(r, c-1) | m_flag_at(r, c+1);
`ifdef FLOOD_DIAG_EN
                        touch = touch | m_flag_at(r-1, c-1) | m_flag_at(r-1, c+1) |
                                m_flag_at(r+1, c-1) | m_flag_at(r+1, c+1);
`endif
                        if (touch) begin
                            m_flag[r][c] = 1;
                            any = 1;
                        end
                    end
                end
            end
        end while (any);
        all = 1;
        for (int r = 0; r < m_size; r++)
            for (int c = 0; c < m_size; c++)
                all = all & m_flag[r][c];
        if (all) m_phase = P_WIN;
        else if (m_max != 0 && m_moves >= m_max) m_phase = P_LOSE;
        else m_phase = P_PLAY;
    endfunction

    function automatic exp_t m_expect(input int kind, input int lat);
        exp_t e;
        e.kind  = kind;
        e.lat   = lat;
        e.moves = m_moves;
        e.flood = m_flood;
        e.win   = (m_phase == P_WIN) ? 1 : 0;
        e.lose  = (m_phase == P_LOSE) ? 1 : 0;
        e.ready = (m_phase == P_PLAY) ? 1 : 0;
        e.disp  = '0;
        for (int r = 0; r < m_size; r++)
            for (int c = 0; c < m_size; c++)
                e.disp[(r*MAX_N+c)*COLOR_W +: COLOR_W] = COLOR_W'(m_flag[r][c] ? m_flood : m_color[r][c]);
        return e;
    endfunction

    always @(posedge clock) begin
        cycle++;
        rst_seen = !reset_n;
        hs_seen  = move_valid && move_ready;
        if (reset_n && (start || (move_valid && move_ready))) op_cycle = cycle;
    end

    // Monitor: pops one expectation per observable response (reset, completion, ignored move)
    initial begin
        exp_t e;
        logic [DISP_W-1:0] d;
        int ev;
        rd_row = '0;
        rd_col = '0;
        forever begin
            @(negedge clock);
            ev = -1;
            if (rst_seen) ev = K_RST;
            else if (busy_prev && !busy) ev = K_DONE;
            else if (hs_seen && !busy) ev = K_IGN;
            if (ev >= 0) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_event actual=%0d required=none", ev);
                end else begin
                    e = sb.pop_front();
                    d = '0;
                    for (int r = 0; r < MAX_N; r++) begin
                        for (int c = 0; c < MAX_N; c++) begin
                            rd_row = IDX_W'(r);
                            rd_col = IDX_W'(c);
                            #0.1;
                            d[(r*MAX_N+c)*COLOR_W +: COLOR_W] = rd_color;
                        end
                    end
                    check_output("event_kind", ev, e.kind);
                    check_output("moves", moves, e.moves);
                    check_output("flood_color", flood_color, e.flood);
                    check_output("win", win, e.win);
                    check_output("lose", lose, e.lose);
                    check_output("move_ready", move_ready, e.ready);
                    check_output("busy", busy, 0);
                    check_disp(d, e.disp);
                    if (ev == K_DONE) check_output("latency", cycle - op_cycle, e.lat);
                end
            end
            busy_prev = busy;
        end
    end

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL timeout actual=%0d required=0 pending", sb.size());
            sb.delete();
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        for (int r = 0; r < MAX_N; r++)
            for (int c = 0; c < MAX_N; c++) begin
                m_color[r][c] = 0;
                m_flag[r][c]  = 0;
            end
        m_size = 0; m_moves = 0; m_flood = 0; m_phase = P_IDLE;
        sb.push_back(m_expect(K_RST, 0));
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        wait_done();
    endtask

    task automatic load_cell(input int r, input int c, input int colr);
        if (m_phase == P_IDLE && r < MAX_N && c < MAX_N) m_color[r][c] = colr;
        load_valid = 1'b1;
        load_row   = IDX_W'(r);
        load_col   = IDX_W'(c);
        load_color = COLOR_W'(colr);
        @(negedge clock);
        load_valid = 1'b0;
    endtask

    task automatic start_game(input int sz, input int num, input int mx, input bit push);
        m_size = (sz == 0) ? 1 : ((sz > MAX_N) ? MAX_N : sz);
        m_num = num; m_max = mx; m_moves = 0;
        for (int r = 0; r < MAX_N; r++)
            for (int c = 0; c < MAX_N; c++)
                m_flag[r][c] = 0;
        m_flag[0][0] = 1;
        m_flood = m_color[0][0];
        m_flood_run();
        if (push) sb.push_back(m_expect(K_DONE, m_passes * m_size * m_size + 1));
        start     = 1'b1;
        size      = IDX_W'(sz);
        color_num = (COLOR_W+1)'(num);
        max_moves = CNT_W'(mx);
        @(negedge clock);
        start = 1'b0;
        if (push) wait_done();
    endtask

    task automatic do_move(input int colr, input bit push);
        if (colr != m_flood && colr < m_num) begin
            if (m_moves < 255) m_moves++;
            m_flood = colr;
            m_flood_run();
            if (push) sb.push_back(m_expect(K_DONE, m_passes * m_size * m_size + 1));
        end else if (push) begin
            sb.push_back(m_expect(K_IGN, 0));
        end
        move_valid = 1'b1;
        move_color = COLOR_W'(colr);
        @(negedge clock);
        move_valid = 1'b0;
        if (push) wait_done();
    endtask

    task automatic load_board3();
        int b[9] = '{0, 1, 1, 1, 1, 2, 2, 2, 2};
        for (int i = 0; i < 9; i++) load_cell(i / 3, i % 3, b[i]);
    endtask

    initial begin
        int sz, nc, mx;
        reset_n = 1'b0; size = '0; color_num = '0; max_moves = '0;
        load_valid = 1'b0; load_row = '0; load_col = '0; load_color = '0;
        start = 1'b0; move_valid = 1'b0; move_color = '0;
        for (int r = 0; r < MAX_N; r++)
            for (int c = 0; c < MAX_N; c++) begin
                m_color[r][c] = 0;
                m_flag[r][c]  = 0;
            end
        m_size = 0; m_moves = 0; m_flood = 0; m_phase = P_IDLE; m_num = 0; m_max = 0;
        sb.push_back(m_expect(K_RST, 0));
        @(negedge clock);
        reset_n = 1'b1;
        wait_done();

        $display("[TB] single cell");
        load_cell(0, 0, 2);
        load_cell(6, 0, 7);
        start_game(1, 3, 0, 1);

        $display("[TB] two-move win with ignored moves and ignored load");
        do_reset();
        load_board3();
        start_game(3, 3, 0, 1);
        do_move(1, 1);
        do_move(1, 1);
        do_move(5, 1);
        load_cell(2, 2, 0);
        do_move(2, 1);

        $display("[TB] lose on move limit");
        do_reset();
        load_board3();
        start_game(3, 3, 1, 1);
        do_move(1, 1);
        move_valid = 1'b1;
        move_color = 3'd2;
        #1 check_output("ready_after_lose", move_ready, 0);
        @(negedge clock);
        move_valid = 1'b0;

        $display("[TB] restart and reset mid-sweep");
        do_reset();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) load_cell(r, c, $urandom_range(0, 3));
        start_game(5, 4, 0, 0);
        repeat (4) @(negedge clock);
        start_game(5, 4, 0, 1);
        if (m_phase == P_PLAY) begin
            do_move((m_flood + 1) % 4, 0);
            repeat (3) @(negedge clock);
        end
        do_reset();

        $display("[TB] diagonal connectivity");
        load_cell(0, 0, 0); load_cell(0, 1, 1); load_cell(1, 0, 1); load_cell(1, 1, 0);
        start_game(2, 2, 0, 1);

        $display("[TB] size clamping");
        do_reset();
        for (int r = 0; r < MAX_N; r++)
            for (int c = 0; c < MAX_N; c++) load_cell(r, c, 3);
        start_game(7, 4, 0, 1);
        do_reset();
        load_cell(0, 0, 1); load_cell(0, 1, 1);
        start_game(0, 2, 0, 1);

        $display("[TB] random games");
        for (int g = 0; g < 8; g++) begin
            do_reset();
            sz = $urandom_range(0, 7);
            nc = $urandom_range(2, 8);
            mx = $urandom_range(0, 6);
            for (int r = 0; r < MAX_N; r++)
                for (int c = 0; c < MAX_N; c++) load_cell(r, c, $urandom_range(0, nc - 1));
            start_game(sz, nc, mx, 1);
            for (int m = 0; m < 25 && m_phase == P_PLAY; m++) do_move($urandom_range(0, 7), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
